instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/if_pkg.sv | 28 ++
 rtl/fetch_buffer.sv | 45 ++++
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// default and the buffer entry layout.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
    localparam int          IF_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    // A new request may be issued only while buffered plus in-flight entries fit.
    function automatic logic has_credit(input logic [1:0] count,
                                        input logic       outstanding,
                                        input int         depth);
        logic [2:0] used;
        used = {1'b0, count} + {2'b00, outstanding};
        return used < 3'(depth);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between the memory response path and the core.
// Flush wins over push and pop in the same cycle.
module fetch_buffer
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  if_entry_t   push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  count,
    output if_entry_t   head
);

    if_entry_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// two-entry buffer, with redirect flush and stale-response tracking.
module instruction_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter int          BUF_DEPTH = IF_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  resp_pc;
    logic         stale;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         accept;
    logic         rsp_done;
    logic         push;
    logic         pop;
    if_entry_t    push_data;
    if_entry_t    head;

    assign accept     = (state == REQ) && imem_ready;
    assign rsp_done   = (state == WAIT) && imem_rvalid;
    assign push       = rsp_done && !stale && !redirect;
    assign inst_valid = (count != 2'd0) && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign push_data  = '{pc: resp_pc, instr: imem_rdata};

    always_comb begin
        count_next = redirect ? 2'd0 : (count + 2'(push) - 2'(pop));
    end

    // A stale request keeps its address on the bus, but the PC already holds
    // the redirect target, so acceptance of it must not advance the PC.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (accept && !stale) begin
            pc_next = pc + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (has_credit(count_next, 1'b0, BUF_DEPTH)) state_next = REQ;
            REQ:  if (imem_ready) state_next = WAIT;
            WAIT: if (imem_rvalid) begin
                state_next = has_credit(count_next, 1'b0, BUF_DEPTH) ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            resp_pc   <= 32'd0;
            stale     <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            imem_req <= (state_next == REQ);
            if ((state_next == REQ) && (state != REQ)) begin
                imem_addr <= pc_next;
            end
            if (accept) begin
                resp_pc <= imem_addr;
            end
            if (rsp_done) begin
                stale <= 1'b0;
            end else if (redirect && ((state == WAIT) || (state == REQ))) begin
                stale <= 1'b1;
            end
        end
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign instruction = head.instr;
    assign inst_pc     = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized run
// checked against a program-order model of delivered instructions.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, inst_ready, redirect;
    logic [31:0] instruction, inst_pc, redirect_pc;

    logic        w_rst_n;
    logic        w_imem_req, w_imem_ready, w_imem_rvalid;
    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_inst_valid, w_inst_ready, w_redirect;
    logic [31:0] w_instruction, w_inst_pc, w_redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .instruction(instruction), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .inst_valid(w_inst_valid), .instruction(w_instruction), .inst_pc(w_inst_pc),
        .inst_ready(w_inst_ready), .redirect(w_redirect), .redirect_pc(w_redirect_pc)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wq_req[$];
        logic [31:0] wq_pc[$];
        logic        w_pend;
        logic [31:0] w_addr;
        logic        mpend, prev_hold;
        logic [31:0] maddr, prev_addr, exp_pc;
        int          mdelay, ndeliv;

        rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        w_rst_n = 1'b0; w_imem_ready = 1'b1; w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        w_inst_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;

        // Reset state
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);

        // Basic fetch: first request at 0, data one cycle after rvalid
        imem_ready = 1'b1; inst_ready = 1'b1; rst_n = 1'b1;
        tick();
        chk("b_req", {31'd0, imem_req}, 32'd1);
        chk("b_addr0", imem_addr, 32'd0);
        tick();
        chk("b_wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
        tick();
        imem_rvalid = 1'b0; inst_ready = 1'b0;
        #1;
        chk("b_valid", {31'd0, inst_valid}, 32'd1);
        chk("b_instr", instruction, 32'hAAAA_0001);
        chk("b_ipc", inst_pc, 32'd0);
        chk("b_addr1", imem_addr, 32'd1);

        // Credit stall with a full buffer
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0002;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("c_stall", {31'd0, imem_req}, 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        chk("c_req", {31'd0, imem_req}, 32'd1);
        chk("c_addr2", imem_addr, 32'd2);
        chk("c_head_pc", inst_pc, 32'd1);
        chk("c_head_instr", instruction, 32'hAAAA_0002);
        tick();

        // Redirect while waiting for a response
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("r_valid_masked", {31'd0, inst_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("r_flushed", {31'd0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0003;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("r_dropped", {31'd0, inst_valid}, 32'd0);
        chk("r_req", {31'd0, imem_req}, 32'd1);
        chk("r_addr", imem_addr, 32'h40);
        inst_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_0040;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("r_valid", {31'd0, inst_valid}, 32'd1);
        chk("r_ipc", inst_pc, 32'h40);
        chk("r_instr", instruction, 32'h1111_0040);

        // Stalled request with a redirect: address must stay put
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            redirect = (i == 1); redirect_pc = 32'h80;
            #1;
            chk("s_req_hold", {31'd0, imem_req}, 32'd1);
            chk("s_addr_hold", imem_addr, 32'h41);
            tick();
        end
        redirect = 1'b0; imem_ready = 1'b1;
        #1;
        chk("s_addr_acc", imem_addr, 32'h41);
        tick();
        chk("s_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0041;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("s_dropped", {31'd0, inst_valid}, 32'd0);
        chk("s_req", {31'd0, imem_req}, 32'd1);
        chk("s_addr", imem_addr, 32'h80);
        inst_ready = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_0080;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("s_ipc", inst_pc, 32'h80);
        chk("s_instr", instruction, 32'h2222_0080);

        // Reset during WAIT with one buffered entry
        tick();
        rst_n = 1'b0;
        #1;
        chk("a_valid", {31'd0, inst_valid}, 32'd0);
        chk("a_req", {31'd0, imem_req}, 32'd0);
        chk("a_addr", imem_addr, 32'd0);
        chk("a_instr", instruction, 32'd0);
        chk("a_ipc", inst_pc, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0081;
        tick();
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("a_req_after", {31'd0, imem_req}, 32'd1);
        chk("a_addr_after", imem_addr, 32'd0);
        chk("a_late_ignored", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_0000;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("a_valid_after", {31'd0, inst_valid}, 32'd1);
        chk("a_ipc_after", inst_pc, 32'd0);
        chk("a_instr_after", instruction, 32'h3333_0000);

        // PC wrap on the second instance
        w_pend = 1'b0; w_addr = '0;
        w_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            w_imem_rvalid = w_pend;
            w_imem_rdata  = memf(w_addr);
            #1;
            if (w_imem_rvalid) w_pend = 1'b0;
            if (w_imem_req && w_imem_ready) begin
                wq_req.push_back(w_imem_addr);
                w_pend = 1'b1;
                w_addr = w_imem_addr;
            end
            if (w_inst_valid && w_inst_ready) begin
                wq_pc.push_back(w_inst_pc);
                chk("w_instr", w_instruction, memf(w_inst_pc));
            end
        end
        chk("w_nreq", {31'd0, wq_req.size() >= 2}, 32'd1);
        chk("w_npc", {31'd0, wq_pc.size() >= 2}, 32'd1);
        chk("w_req0", (wq_req.size() > 0) ? wq_req[0] : 32'hX, 32'hFFFF_FFFF);
        chk("w_req1", (wq_req.size() > 1) ? wq_req[1] : 32'hX, 32'h0);
        chk("w_pc0", (wq_pc.size() > 0) ? wq_pc[0] : 32'hX, 32'hFFFF_FFFF);
        chk("w_pc1", (wq_pc.size() > 1) ? wq_pc[1] : 32'hX, 32'h0);

        // Randomized run: delivered stream must follow program order
        imem_rvalid = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mpend = 1'b0; maddr = '0; mdelay = 0; prev_hold = 1'b0; prev_addr = '0;
        exp_pc = 32'd0; ndeliv = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            imem_ready = ($urandom_range(0, 9) < 7);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1000));
            imem_rvalid = mpend && (mdelay == 0);
            imem_rdata  = imem_rvalid ? memf(maddr) : $urandom;
            #1;
            if (prev_hold) begin
                chk("q_req_stable", {31'd0, imem_req}, 32'd1);
                chk("q_addr_stable", imem_addr, prev_addr);
            end
            if (imem_rvalid) mpend = 1'b0;
            else if (mpend) mdelay--;
            if (imem_req && imem_ready) begin
                chk("q_single_outstanding", {31'd0, mpend}, 32'd0);
                mpend  = 1'b1;
                maddr  = imem_addr;
                mdelay = $urandom_range(0, 3);
            end
            prev_hold = imem_req && !imem_ready;
            prev_addr = imem_addr;
            if (redirect) begin
                chk("q_valid_masked", {31'd0, inst_valid}, 32'd0);
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                chk("q_ipc", inst_pc, exp_pc);
                chk("q_instr", instruction, memf(exp_pc));
                exp_pc = exp_pc + 32'd1;
                ndeliv++;
            end
        end
        chk("q_progress", {31'd0, ndeliv > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
